synapse_array: RTL and testbench

SYNAPSE_ARRAY -- requirements
Module: synapse_array

---
 rtl/synapse_pkg.sv | 20 ++
 rtl/synapse_mac.sv | 25 ++
 rtl/synapse_array.sv | 159 +++++++++++++++
 tb/tb_synapse_array.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/synapse_pkg.sv
// Shared types and sizing helpers for the synapse array.
package synapse_pkg;

    // Sequencer states:
    //   ST_IDLE  | waiting for a channel vector, in_ready_o high
    //   ST_ACCUM | walking the channels, one multiply-accumulate per edge
    //   ST_DONE  | result held on data_o until the consumer takes it
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Accumulator width that cannot overflow: full product width
    // (unsigned data widened by one sign bit) plus growth for N_CH terms.
    function automatic int acc_width(input int data_w, input int weight_w, input int n_ch);
        return data_w + weight_w + $clog2(n_ch) + 1;
    endfunction

endpackage

// File: rtl/synapse_mac.sv
// Single multiply-accumulate step: acc_next = acc + zero-extended data * signed weight.
module synapse_mac
    import synapse_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int ACC_W    = acc_width(8, 8, 4)
) (
    input  logic signed [ACC_W-1:0]    acc,
    input  logic        [DATA_W-1:0]   data,
    input  logic signed [WEIGHT_W-1:0] weight,
    output logic signed [ACC_W-1:0]    acc_next
);

    localparam int PROD_W = DATA_W + WEIGHT_W + 1;

    logic signed [DATA_W:0]   data_s;
    logic signed [PROD_W-1:0] prod;

    // A leading zero bit makes the unsigned datum a non-negative signed operand.
    assign data_s   = signed'({1'b0, data});
    assign prod     = PROD_W'(data_s) * PROD_W'(weight);
    assign acc_next = acc + ACC_W'(prod);

endmodule

// File: rtl/synapse_array.sv
// Weighted-sum synapse: captures N_CH data/weight pairs, accumulates them one
// channel per clock through synapse_mac, then presents a shifted and reduced
// signed result with a valid/ready handshake.
// Optional build macro: SYNAPSE_ARRAY_SAT_EN selects saturating output
// reduction; without it the output wraps to the low OUT_W bits.
module synapse_array
    import synapse_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int N_CH     = 4,
    parameter int OUT_W    = 8,
    parameter int SHIFT    = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [N_CH*DATA_W-1:0]     data_i,
    input  logic [N_CH*WEIGHT_W-1:0]   weight_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic signed [OUT_W-1:0]    data_o
);

    localparam int ACC_W = acc_width(DATA_W, WEIGHT_W, N_CH);
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

    state_t state;
    state_t state_next;

    logic [N_CH*DATA_W-1:0]   data_q;
    logic [N_CH*WEIGHT_W-1:0] weight_q;
    logic [IDX_W-1:0]         idx;

    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    acc_next;
    logic signed [ACC_W-1:0]    acc_shift;
    logic        [DATA_W-1:0]   cur_data;
    logic signed [WEIGHT_W-1:0] cur_weight;
    logic signed [OUT_W-1:0]    reduced;

    logic accept;
    logic last_ch;

    // Ready is gated by reset so nothing is accepted on a reset edge.
    assign in_ready_o  = (state == ST_IDLE) && rst_ni;
    assign accept      = in_valid_i && in_ready_o;
    assign last_ch     = (idx == LAST_IDX);
    assign out_valid_o = (state == ST_DONE);

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: accept -> walk channels -> hold until consumed.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (last_ch) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Select the captured channel addressed by the current index.
    always_comb begin
        cur_data   = '0;
        cur_weight = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_data   = data_q[k*DATA_W +: DATA_W];
                cur_weight = weight_q[k*WEIGHT_W +: WEIGHT_W];
            end
        end
    end

    synapse_mac #(
        .DATA_W   (DATA_W),
        .WEIGHT_W (WEIGHT_W),
        .ACC_W    (ACC_W)
    ) u_mac (
        .acc      (acc),
        .data     (cur_data),
        .weight   (cur_weight),
        .acc_next (acc_next)
    );

    // Output is formed from acc_next so the result lands on the same edge
    // that adds the final channel.
    assign acc_shift = acc_next >>> SHIFT;

`ifdef SYNAPSE_ARRAY_SAT_EN
    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((longint'(1) <<< (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

    // Clamp the shifted sum into the signed output range.
    always_comb begin
        if (acc_shift > OUT_MAX) begin
            reduced = OUT_MAX[OUT_W-1:0];
        end else if (acc_shift < OUT_MIN) begin
            reduced = OUT_MIN[OUT_W-1:0];
        end else begin
            reduced = acc_shift[OUT_W-1:0];
        end
    end
`else
    // Wrap: keep only the low OUT_W bits of the shifted sum.
    assign reduced = OUT_W'(acc_shift);
`endif

    // Capture registers, accumulator, channel index and registered result.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            data_q   <= '0;
            weight_q <= '0;
            acc      <= '0;
            idx      <= '0;
            data_o   <= '0;
        end else begin
            if (accept) begin
                data_q   <= data_i;
                weight_q <= weight_i;
                acc      <= '0;
                idx      <= '0;
            end else if (state == ST_ACCUM) begin
                acc <= acc_next;
                if (last_ch) begin
                    idx    <= '0;
                    data_o <= reduced;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_synapse_array.sv
// Bench for synapse_array: a default instance and a SHIFT=2 instance share
// stimulus; expected results are queued at acceptance and checked when the
// output valid rises.
module tb_synapse_array;

    localparam int N_CH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] data;
    logic [31:0] weight;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  dout;
    logic        in_ready_sh;
    logic        out_valid_sh;
    logic [7:0]  dout_sh;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    synapse_array u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .data_i      (data),
        .weight_i    (weight),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .data_o      (dout)
    );

    synapse_array #(.SHIFT(2)) u_dut_sh (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready_sh),
        .data_i      (data),
        .weight_i    (weight),
        .out_valid_o (out_valid_sh),
        .out_ready_i (out_ready),
        .data_o      (dout_sh)
    );

    typedef struct {
        logic [7:0] d[4];
        logic [7:0] w[4];
        logic [7:0] exp;
        logic [7:0] exp_sh;
    } vec_t;

    typedef struct {
        logic [7:0] exp;
        logic [7:0] exp_sh;
        int         acc_cyc;
    } sb_t;

    sb_t  sb[$];
    sb_t  mon_e;
    vec_t tbl[8];
    logic prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] d0, input logic [7:0] d1,
                                input logic [7:0] d2, input logic [7:0] d3,
                                input logic [7:0] w0, input logic [7:0] w1,
                                input logic [7:0] w2, input logic [7:0] w3,
                                input logic [7:0] e, input logic [7:0] es);
        vec_t v;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = w3;
        v.exp = e;
        v.exp_sh = es;
        return v;
    endfunction

    function automatic logic [31:0] pack(input logic [7:0] a[4]);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[k*8 +: 8] = a[k];
        return r;
    endfunction

    // Scoreboard monitor: compare on each rising edge of out_valid.
    always @(negedge clk) begin
        if (out_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("data_o", {24'd0, dout}, {24'd0, mon_e.exp});
                check("data_o_shift2", {24'd0, dout_sh}, {24'd0, mon_e.exp_sh});
                check("latency", cyc - mon_e.acc_cyc, N_CH);
                check("valid_sh_match", {31'd0, out_valid_sh}, 32'd1);
            end
        end
        prev_valid = out_valid;
    end

    task automatic offer(input vec_t v);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        data     = pack(v.d);
        weight   = pack(v.w);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
        check("ready_sh_match", {31'd0, in_ready_sh}, {31'd0, in_ready});
        sb.push_back('{v.exp, v.exp_sh, cyc + 1});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        data     = $urandom;
        weight   = $urandom;
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) check("result_timeout", 32'd0, 32'd1);
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("valid_clears", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic valid_seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data      = '0;
        weight    = '0;

        tbl[0] = mk(8'd10, 8'd20, 8'd30, 8'd40, 8'h01, 8'h01, 8'h01, 8'h01, 8'h64, 8'h19);
        tbl[1] = mk(8'd10, 8'd20, 8'd30, 8'd40, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h9C, 8'hE7);
`ifdef SYNAPSE_ARRAY_SAT_EN
        tbl[2] = mk(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F);
        tbl[5] = mk(8'hFF, 8'h00, 8'h00, 8'h00, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80);
        tbl[7] = mk(8'd100, 8'd50, 8'd0, 8'd1, 8'h01, 8'h02, 8'h7F, 8'hFF, 8'h7F, 8'h31);
`else
        tbl[2] = mk(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h04, 8'h81);
        tbl[5] = mk(8'hFF, 8'h00, 8'h00, 8'h00, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h20);
        tbl[7] = mk(8'd100, 8'd50, 8'd0, 8'd1, 8'h01, 8'h02, 8'h7F, 8'hFF, 8'hC7, 8'h31);
`endif
        tbl[3] = mk(8'd1, 8'd2, 8'd3, 8'd4, 8'h02, 8'h02, 8'h02, 8'h02, 8'h14, 8'h05);
        tbl[4] = mk(8'd0, 8'd0, 8'd0, 8'd0, 8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h00);
        tbl[6] = mk(8'd3, 8'd5, 8'd7, 8'd9, 8'h01, 8'hFE, 8'h03, 8'hFC, 8'hEA, 8'hFA);

        // Reset state.
        repeat (2) @(negedge clk);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_data_o", {24'd0, dout}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", {31'd0, in_ready}, 32'd1);

        // Table vectors.
        for (int i = 0; i < 8; i++) begin
            offer(tbl[i]);
            wait_result();
            @(negedge clk);
            check("hold_data_o", {24'd0, dout}, {24'd0, tbl[i].exp});
            release_result();
        end

        // Back-pressure with a new vector waiting.
        offer(tbl[0]);
        wait_result();
        in_valid = 1'b1;
        data     = pack(tbl[1].d);
        weight   = pack(tbl[1].w);
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_data_stable", {24'd0, dout}, {24'd0, tbl[0].exp});
            check("bp_valid_held", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_valid_clears", {31'd0, out_valid}, 32'd0);
        check("bp_ready_in_idle", {31'd0, in_ready}, 32'd1);
        sb.push_back('{tbl[1].exp, tbl[1].exp_sh, cyc + 1});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_accepted", {31'd0, in_ready}, 32'd0);
        wait_result();
        release_result();

        // Reset in the middle of accumulation discards the transaction.
        @(negedge clk);
        in_valid = 1'b1;
        data     = pack(tbl[0].d);
        weight   = pack(tbl[0].w);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_ready", {31'd0, in_ready}, 32'd1);
        valid_seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) valid_seen = 1'b1;
        end
        check("abort_no_output", {31'd0, valid_seen}, 32'd0);
        offer(tbl[3]);
        wait_result();
        release_result();

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
